// File: rtl/sr_seq_pkg.sv
// Shared types and default widths for the SR flip-flop drive sequencer.
package sr_seq_pkg;

    localparam int unsigned HOLD_W_DEF = 4;
    localparam int unsigned CHG_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sr_hold_counter.sv
// Down-counter for the post-action settle period: load, decrement, zero/last flags.
module sr_hold_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        zero = (cnt == '0);
        last = (cnt == W'(1));
    end

endmodule

// File: rtl/sr_drive_sequencer.sv
// Sequences set/reset pulses to a downstream SR flip-flop with per-request settle time.
// Optional feedback mismatch checker enabled by macro SR_FB_CHECK_EN.
module sr_drive_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned HOLD_W = HOLD_W_DEF,
    parameter int unsigned CHG_W  = CHG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_target,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              s,
    output logic              r,
    output logic              q_model,
    output logic              busy,
    output logic [CHG_W-1:0]  changes
`ifdef SR_FB_CHECK_EN
    ,
    input  logic              q_fb,
    output logic              fb_err
`endif
);

    seq_state_t state;
    seq_state_t next_state;
    logic       accept;
    logic       target_q;
    logic       hold_zero;
    logic       hold_last;

    assign accept = req_valid && req_ready;

    // The counter doubles as the latched hold value while DRIVE is in progress.
    sr_hold_counter #(
        .W (HOLD_W)
    ) u_hold_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (req_hold),
        .dec      (state == HOLD),
        .zero     (hold_zero),
        .last     (hold_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_target != q_model) begin
                        next_state = DRIVE;
                    end else if (req_hold != '0) begin
                        next_state = HOLD;
                    end
                end
            end
            DRIVE:   next_state = hold_zero ? IDLE : HOLD;
            HOLD:    next_state = hold_last ? IDLE : HOLD;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        busy      = (state != IDLE);
        s         = (state == DRIVE) && target_q;
        r         = (state == DRIVE) && !target_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q <= 1'b0;
            q_model  <= 1'b0;
            changes  <= '0;
        end else begin
            if (accept) begin
                target_q <= req_target;
            end
            if (state == DRIVE) begin
                q_model <= target_q;
                if (changes != '1) begin
                    changes <= changes + 1'b1;
                end
            end
        end
    end

`ifdef SR_FB_CHECK_EN
    // The downstream flop may still be settling on the first edge after reset release.
    logic fb_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_err   <= 1'b0;
            fb_first <= 1'b1;
        end else begin
            fb_first <= 1'b0;
            if (!fb_first && (q_fb != q_model)) begin
                fb_err <= 1'b1;
            end
        end
    end
`endif

endmodule
